// File: rtl/timer_pkg.sv
// Shared encodings for the timer0 count/compare path.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_PC_PWM   = 2'b01,
        MODE_CTC      = 2'b10,
        MODE_FAST_PWM = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // PWM modes double-buffer OCR; the others write it straight through.
    function automatic logic is_pwm(input mode_e m);
        return (m == MODE_PC_PWM) || (m == MODE_FAST_PWM);
    endfunction

endpackage

// File: rtl/dff_en_ar.sv
// Enabled register with asynchronous active-high clear to RESETVAL.
module dff_en_ar #(
    parameter int               WIDTH    = 1,
    parameter logic [WIDTH-1:0] RESETVAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)     q <= RESETVAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/timer_counter_core.sv
// Timer0 count/compare core: counter, double-buffered compare, overflow and
// compare-match events and the waveform output for the four WGM0 modes.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESETVAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             cnt_we,
    input  logic [WIDTH-1:0] cnt_wdata,
    input  logic             ocr_we,
    input  logic [WIDTH-1:0] ocr_wdata,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] ocr,
    output logic             dir,
    output logic             tov_pulse,
    output logic             ocf_pulse,
    output logic             oc_out
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            m;
    logic             pwm, step, at_max, at_bot, eq, match, blk;
    logic [WIDTH-1:0] ocr_buf;
    logic [WIDTH-1:0] cnt_d, ocr_d, buf_d;
    logic             cnt_en, ocr_en;
    logic             dir_d, blk_d, oc_d, tov_d, ocf_d;

    assign m      = mode_e'(mode);
    assign pwm    = is_pwm(m);
    // A TCNT write in the same cycle swallows the tick entirely.
    assign step   = tick & ~cnt_we;
    assign at_max = (cnt == MAX);
    assign at_bot = (cnt == '0);
    assign eq     = (cnt == ocr);
    assign match  = step & eq & ~blk;

    assign cnt_en = cnt_we | step;
    assign ocr_en = ~pwm | (step & at_max);

    always_comb begin
        cnt_d = cnt;
        dir_d = dir;
        blk_d = blk;
        oc_d  = oc_out;
        tov_d = 1'b0;
        ocf_d = match;
        buf_d = ocr_wdata;
        // Non-PWM keeps ocr tracking ocr_buf, which also covers the copy on mode entry.
        if (!pwm) ocr_d = ocr_we ? ocr_wdata : ocr_buf;
        else      ocr_d = ocr_buf;

        if (cnt_we) begin
            cnt_d = cnt_wdata;
            blk_d = 1'b1;
        end else if (step) begin
            blk_d = 1'b0;
            case (m)
                MODE_NORMAL: begin
                    cnt_d = cnt + ONE;
                    tov_d = at_max;
                    if (match) oc_d = ~oc_out;
                end
                MODE_CTC: begin
                    cnt_d = eq ? '0 : cnt + ONE;
                    tov_d = at_max;
                    if (match) oc_d = ~oc_out;
                end
                MODE_FAST_PWM: begin
                    cnt_d = cnt + ONE;
                    tov_d = at_max;
                    if (at_max)     oc_d = 1'b1;
                    else if (match) oc_d = 1'b0;
                end
                MODE_PC_PWM: begin
                    if (dir == DIR_UP) begin
                        if (at_max) begin
                            dir_d = DIR_DOWN;
                            cnt_d = MAX - ONE;
                        end else begin
                            cnt_d = cnt + ONE;
                        end
                    end else begin
                        if (at_bot) begin
                            dir_d = DIR_UP;
                            cnt_d = ONE;
                            tov_d = 1'b1;
                        end else begin
                            cnt_d = cnt - ONE;
                        end
                    end
                    if (match) oc_d = (dir == DIR_DOWN);
                end
            endcase
        end

        if (m != MODE_PC_PWM) dir_d = DIR_UP;
    end

    dff_en_ar #(.WIDTH(WIDTH), .RESETVAL(RESETVAL)) u_cnt (
        .clk(clk), .clr(clr), .en(cnt_en), .d(cnt_d), .q(cnt)
    );
    dff_en_ar #(.WIDTH(WIDTH)) u_ocr (
        .clk(clk), .clr(clr), .en(ocr_en), .d(ocr_d), .q(ocr)
    );
    dff_en_ar #(.WIDTH(WIDTH)) u_ocr_buf (
        .clk(clk), .clr(clr), .en(ocr_we), .d(buf_d), .q(ocr_buf)
    );
    dff_en_ar #(.WIDTH(1)) u_dir (
        .clk(clk), .clr(clr), .en(1'b1), .d(dir_d), .q(dir)
    );
    dff_en_ar #(.WIDTH(1)) u_blk (
        .clk(clk), .clr(clr), .en(1'b1), .d(blk_d), .q(blk)
    );
    dff_en_ar #(.WIDTH(1)) u_oc (
        .clk(clk), .clr(clr), .en(1'b1), .d(oc_d), .q(oc_out)
    );
    dff_en_ar #(.WIDTH(1)) u_tov (
        .clk(clk), .clr(clr), .en(1'b1), .d(tov_d), .q(tov_pulse)
    );
    dff_en_ar #(.WIDTH(1)) u_ocf (
        .clk(clk), .clr(clr), .en(1'b1), .d(ocf_d), .q(ocf_pulse)
    );

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed bench for timer_counter_core, WIDTH = 8, RESETVAL = 0.
module tb_timer_counter_core;
    import timer_pkg::*;

    logic       clk, clr, tick, cnt_we, ocr_we;
    logic [1:0] mode;
    logic [7:0] cnt_wdata, ocr_wdata;
    logic [7:0] cnt, ocr;
    logic       dir, tov_pulse, ocf_pulse, oc_out;

    int checks = 0;
    int errors = 0;

    timer_counter_core #(.WIDTH(8), .RESETVAL(8'h00)) dut (
        .clk(clk), .clr(clr), .tick(tick), .mode(mode),
        .cnt_we(cnt_we), .cnt_wdata(cnt_wdata),
        .ocr_we(ocr_we), .ocr_wdata(ocr_wdata),
        .cnt(cnt), .ocr(ocr), .dir(dir),
        .tov_pulse(tov_pulse), .ocf_pulse(ocf_pulse), .oc_out(oc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given tick; strobes drop #1 after the edge.
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
        cnt_we = 1'b0;
        ocr_we = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    task automatic wr_cnt(input logic [7:0] v);
        cnt_we = 1'b1;
        cnt_wdata = v;
    endtask

    task automatic wr_ocr(input logic [7:0] v);
        ocr_we = 1'b1;
        ocr_wdata = v;
    endtask

    initial begin
        clr = 1'b1; tick = 1'b0; mode = MODE_NORMAL;
        cnt_we = 1'b0; cnt_wdata = '0; ocr_we = 1'b0; ocr_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", cnt, 8'h00);
        chk("rst_ocr", ocr, 8'h00);
        chk("rst_dir", dir, 1'b0);
        chk("rst_tov", tov_pulse, 1'b0);
        chk("rst_ocf", ocf_pulse, 1'b0);
        chk("rst_oc", oc_out, 1'b0);
        clr = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk("idle_cnt", cnt, 8'h00);
        chk("idle_flags", {tov_pulse, ocf_pulse}, 2'b00);

        // Normal: FE -> FF -> 00 with overflow on the wrap
        wr_ocr(8'h10); cyc(1'b0);
        chk("nrm_ocr", ocr, 8'h10);
        wr_cnt(8'hFE); cyc(1'b0);
        chk("nrm_load", cnt, 8'hFE);
        cyc(1'b1);
        chk("nrm_ff", cnt, 8'hFF);
        chk("nrm_ff_tov", tov_pulse, 1'b0);
        cyc(1'b1);
        chk("nrm_wrap", cnt, 8'h00);
        chk("nrm_wrap_tov", tov_pulse, 1'b1);
        chk("nrm_wrap_ocf", ocf_pulse, 1'b0);
        cyc(1'b0);
        chk("nrm_tov_one", tov_pulse, 1'b0);

        // CTC: ocr = 3, 0 -> 1 -> 2 -> 3 -> 0 -> 1
        mode = MODE_CTC;
        wr_ocr(8'h03); wr_cnt(8'h00); cyc(1'b0);
        chk("ctc_ocr", ocr, 8'h03);
        run(3);
        chk("ctc_3", cnt, 8'h03);
        chk("ctc_3_ocf", ocf_pulse, 1'b0);
        cyc(1'b1);
        chk("ctc_clear", cnt, 8'h00);
        chk("ctc_clear_ocf", ocf_pulse, 1'b1);
        chk("ctc_clear_oc", oc_out, 1'b1);
        chk("ctc_clear_tov", tov_pulse, 1'b0);
        cyc(1'b1);
        chk("ctc_1", cnt, 8'h01);
        chk("ctc_1_ocf", ocf_pulse, 1'b0);

        // Fast PWM: ocr 0x80 buffered write of 0x40 at cnt 0x10
        wr_ocr(8'h80); wr_cnt(8'h10); cyc(1'b0);
        mode = MODE_FAST_PWM;
        wr_ocr(8'h40); cyc(1'b0);
        chk("fp_ocr_hold", ocr, 8'h80);
        run(8'h70);
        chk("fp_80", cnt, 8'h80);
        chk("fp_80_oc", oc_out, 1'b1);
        cyc(1'b1);
        chk("fp_match_ocf", ocf_pulse, 1'b1);
        chk("fp_match_oc", oc_out, 1'b0);
        run(8'h7E);
        chk("fp_ff", cnt, 8'hFF);
        chk("fp_ff_ocr", ocr, 8'h80);
        cyc(1'b1);
        chk("fp_wrap_cnt", cnt, 8'h00);
        chk("fp_wrap_ocr", ocr, 8'h40);
        chk("fp_wrap_tov", tov_pulse, 1'b1);
        chk("fp_wrap_oc", oc_out, 1'b1);
        run(8'h40);
        chk("fp_40_oc", oc_out, 1'b1);
        cyc(1'b1);
        chk("fp_40_cnt", cnt, 8'h41);
        chk("fp_40_ocf", ocf_pulse, 1'b1);
        chk("fp_40_oc_clr", oc_out, 1'b0);

        // Phase-correct: turn at the top, run down, turn at the bottom
        mode = MODE_PC_PWM;
        wr_cnt(8'hFE); wr_ocr(8'h80); cyc(1'b0);
        chk("pc_ocr_buffered", ocr, 8'h40);
        cyc(1'b1);
        chk("pc_ff", cnt, 8'hFF);
        chk("pc_ff_dir", dir, 1'b0);
        cyc(1'b1);
        chk("pc_top_cnt", cnt, 8'hFE);
        chk("pc_top_dir", dir, 1'b1);
        chk("pc_top_ocr", ocr, 8'h80);
        chk("pc_top_tov", tov_pulse, 1'b0);
        run(8'h7E);
        chk("pc_dn80", cnt, 8'h80);
        chk("pc_dn80_oc", oc_out, 1'b0);
        cyc(1'b1);
        chk("pc_dn_match_ocf", ocf_pulse, 1'b1);
        chk("pc_dn_match_oc", oc_out, 1'b1);
        run(8'h7F);
        chk("pc_bot", cnt, 8'h00);
        chk("pc_bot_tov_pre", tov_pulse, 1'b0);
        cyc(1'b1);
        chk("pc_turn_cnt", cnt, 8'h01);
        chk("pc_turn_dir", dir, 1'b0);
        chk("pc_turn_tov", tov_pulse, 1'b1);
        run(8'h7F);
        chk("pc_up80", cnt, 8'h80);
        cyc(1'b1);
        chk("pc_up_match_ocf", ocf_pulse, 1'b1);
        chk("pc_up_match_oc", oc_out, 1'b0);

        // Compare block after a TCNT write
        mode = MODE_NORMAL;
        wr_ocr(8'h20); cyc(1'b0);
        chk("blk_ocr", ocr, 8'h20);
        wr_cnt(8'h20); cyc(1'b1);
        chk("blk_load", cnt, 8'h20);
        chk("blk_load_ocf", ocf_pulse, 1'b0);
        cyc(1'b1);
        chk("blk_step", cnt, 8'h21);
        chk("blk_step_ocf", ocf_pulse, 1'b0);
        chk("blk_step_oc", oc_out, 1'b0);
        wr_cnt(8'h1F); cyc(1'b0);
        run(2);
        chk("blk_pass", cnt, 8'h21);
        chk("blk_pass_ocf", ocf_pulse, 1'b1);
        chk("blk_pass_oc", oc_out, 1'b1);

        // Asynchronous reset mid-count while counting down
        mode = MODE_PC_PWM;
        wr_cnt(8'hFF); cyc(1'b0);
        cyc(1'b1);
        wr_cnt(8'h55); cyc(1'b0);
        chk("ar_pre_cnt", cnt, 8'h55);
        chk("ar_pre_dir", dir, 1'b1);
        #2;
        clr = 1'b1;
        #1;
        chk("ar_cnt", cnt, 8'h00);
        chk("ar_dir", dir, 1'b0);
        chk("ar_ocr", ocr, 8'h00);
        chk("ar_oc", oc_out, 1'b0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk("ar_rel_flags", {tov_pulse, ocf_pulse}, 2'b00);
        chk("ar_rel_cnt", cnt, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_counter_core.md
Name: timer_counter_core

Overview:
- Parametrised count/compare core for the timer0 path: counter register, output-compare register with PWM double-buffering, and overflow/compare event generation.
- Supports the four WGM0 waveform modes.
- Sits between the prescaler (supplies `tick`) and the TIMSK/TIFR/OC0 logic (consumes `tov_pulse`, `ocf_pulse`, `oc_out`).
- Generalises the single enabled register to WIDTH-bit count, compare and buffer registers with mode-dependent update rules.

Parameters:
- WIDTH, 8, counter/compare width; MAX = 2^WIDTH-1, BOTTOM = 0.
- RESETVAL, 0, reset value of `cnt`.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- tick  in  1  count enable from prescaler, one clk cycle per timer step.
- mode  in  2  WGM0 mode: 00 normal, 01 phase-correct PWM, 10 CTC, 11 fast PWM.
- cnt_we  in  1  CPU write strobe for TCNT.
- cnt_wdata  in  WIDTH  TCNT write data.
- ocr_we  in  1  CPU write strobe for OCR.
- ocr_wdata  in  WIDTH  OCR write data.
- cnt  out  WIDTH  current count.
- ocr  out  WIDTH  active compare value.
- dir  out  1  0 = counting up, 1 = counting down (phase-correct only).
- tov_pulse  out  1  one-cycle overflow event.
- ocf_pulse  out  1  one-cycle compare-match event.
- oc_out  out  1  waveform output.

Behaviour:
- **Reset** (`clr` = 1, asynchronous): cnt = RESETVAL; ocr = 0; ocr_buf = 0; dir = 0; tov_pulse = 0; ocf_pulse = 0; oc_out = 0; blk = 0.
- **Registered outputs:** all outputs are registered. Flags assert the cycle after the qualifying edge and last exactly one clk cycle.
- **Idle:** with `tick` = 0 and no writes, all state holds and flags are 0.
- **Counting on tick:**
  - Normal: cnt + 1 mod 2^WIDTH; tov when cnt == MAX (wrap to 0).
  - CTC: if cnt == ocr then cnt = 0, else cnt + 1; tov when cnt == MAX wraps to 0.
  - Fast PWM: cnt + 1, wraps MAX -> 0; tov on the wrap.
  - Phase-correct:
    - Up: cnt + 1 until MAX, then dir = 1 and cnt = MAX - 1.
    - Down: cnt - 1 until 0, then dir = 0 and cnt = 1.
    - tov on the tick where cnt == 0 and dir == 1.
- **Compare match:** on a tick with cnt == ocr and blk == 0, `ocf_pulse` asserts.
- **oc_out on compare match:**
  - Normal/CTC: toggle.
  - Fast PWM: clear on match; set on the MAX -> 0 wrap. Set wins if ocr == MAX.
  - Phase-correct: clear on match while up; set on match while down.
- **OCR write:**
  - Normal/CTC: ocr_buf and ocr both take ocr_wdata on the next edge.
  - PWM modes: only ocr_buf is written. ocr <= ocr_buf on the tick where cnt == MAX.
- **TCNT write:**
  - `cnt_we` loads cnt_wdata, dir is unchanged, and blk = 1.
  - blk suppresses the compare match of the next tick only; that tick clears blk.
  - A write never raises tov.
- **Simultaneous events:**
  - `cnt_we` and `tick` in the same cycle: the write wins, there is no count step and no flags.
  - `ocr_we` and the PWM update point in the same cycle: ocr takes the old ocr_buf, and ocr_buf takes the new data.
- **Mode change:** takes effect on the next edge. Leaving phase-correct forces dir = 0. Entering normal/CTC copies ocr_buf to ocr.
- **Reset mid-count:** all state returns to reset values immediately; no pulse is emitted afterwards until a qualifying tick.

Decomposition:
- Shared package `timer_pkg`:
  - mode encodings MODE_NORMAL, MODE_PC_PWM, MODE_CTC, MODE_FAST_PWM.
  - dir constants DIR_UP/DIR_DOWN.
- One natural sub-module: `dff_en_ar`, a WIDTH-parametrised enabled register with async active-high clear and RESETVAL.
  - Instantiated for cnt, ocr, ocr_buf and the single-bit state (dir, blk, oc_out).
  - Next-state logic stays in `timer_counter_core`.

Test Plan:
1. Normal mode: load cnt = 0xFE, two ticks -> cnt = 0xFF, then 0x00; tov_pulse high one cycle after the second tick, ocf never asserts (ocr = 0x10).
2. CTC: ocr = 0x03, ticks from 0 -> cnt sequence 1, 2, 3, 0, 1; ocf_pulse on the 3 -> 0 tick; oc_out toggles 0 -> 1; no tov.
3. Fast PWM: ocr = 0x80, write ocr = 0x40 at cnt = 0x10 -> ocr output stays 0x80 until the tick at cnt = 0xFF, then 0x40. oc_out is set at wrap and cleared at cnt = 0x40.
4. Phase-correct: start at cnt = 0xFE, up -> 0xFF, then 0xFE with dir = 1; run down to 0 -> tov at the 0 -> 1 turn. With ocr = 0x80, oc_out clears on the up match and sets on the down match.
5. Compare block: ocr = 0x20, cnt_we = 0x20 with tick in the same cycle -> cnt = 0x20, no count, no ocf. Next tick -> cnt = 0x21, no ocf. Later pass through 0x20 -> ocf asserts.
6. Reset mid-operation: assert clr between edges at cnt = 0x55, dir = 1 -> cnt = 0, dir = 0, ocr = 0, oc_out = 0 immediately, with no flag on release.
